// File: rtl/fft_frame_streamer.sv
// Frame source for the vector FFT core: a word-writable buffer of complex frames
// streamed out one full LANES-wide vector per valid/ready beat, optionally looping.
module fft_frame_streamer #(
  parameter int FORMAT_WIDTH = 9,
  parameter int LANES        = 32,
  parameter int FRAMES       = 6,
  parameter int FRAME_AW     = 3,
  parameter int ADDR_WIDTH   = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [FORMAT_WIDTH-1:0]       wr_data,
  input  logic                          start,
  input  logic [FRAME_AW-1:0]           num_frames,
  input  logic                          loop_mode,
  input  logic                          stop,
  output logic                          vec_valid,
  input  logic                          vec_ready,
  output logic [FORMAT_WIDTH*LANES-1:0] vec_real,
  output logic [FORMAT_WIDTH*LANES-1:0] vec_imag,
  output logic [FRAME_AW-1:0]           frame_idx,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   beat_count
);

  localparam int DEPTH = 2 * LANES * FRAMES;
  localparam int VW    = FORMAT_WIDTH * LANES;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state, state_nx;
  logic [FORMAT_WIDTH-1:0] mem [DEPTH];
  logic [FRAME_AW-1:0]     last_idx;
  logic                    loop_q;
  logic                    stop_pend;

  logic                    hs, is_last, end_stream, load;
  logic [FRAME_AW-1:0]     load_idx, n_clamp;
  logic [ADDR_WIDTH-1:0]   base;
  logic [VW-1:0]           rd_real, rd_imag;

  // NOTE: the buffer has no reset; only control and output registers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < ADDR_WIDTH'(DEPTH)))
      mem[wr_addr] <= wr_data;
  end

  assign hs         = (state == STREAM) && vec_ready;
  assign is_last    = (frame_idx == last_idx);
  assign end_stream = hs && (stop_pend || stop || (is_last && !loop_q));
  assign n_clamp    = (num_frames > FRAME_AW'(FRAMES)) ? FRAME_AW'(FRAMES) : num_frames;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_idx = frame_idx + 1'b1;
    case (state)
      IDLE: begin
        if (start && (num_frames != '0)) begin
          state_nx = STREAM;
          load     = 1'b1;
          load_idx = '0;
        end
      end
      STREAM: begin
        if (end_stream) begin
          state_nx = IDLE;
        end else if (hs) begin
          load = 1'b1;
          if (is_last) load_idx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reading the array before the clocked write lands gives read-before-write.
  always_comb begin
    base    = ADDR_WIDTH'(load_idx) * ADDR_WIDTH'(2 * LANES);
    rd_real = '0;
    rd_imag = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_real[VW-1-k*FORMAT_WIDTH -: FORMAT_WIDTH] = mem[base + ADDR_WIDTH'(k)];
      rd_imag[VW-1-k*FORMAT_WIDTH -: FORMAT_WIDTH] = mem[base + ADDR_WIDTH'(LANES + k)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_idx   <= '0;
      loop_q     <= 1'b0;
      stop_pend  <= 1'b0;
      done       <= 1'b0;
      frame_idx  <= '0;
      beat_count <= '0;
      vec_real   <= '0;
      vec_imag   <= '0;
    end else begin
      done <= end_stream;
      if (load) begin
        frame_idx <= load_idx;
        vec_real  <= rd_real;
        vec_imag  <= rd_imag;
      end
      if (state == IDLE) begin
        if (load) begin
          last_idx   <= n_clamp - 1'b1;
          loop_q     <= loop_mode;
          stop_pend  <= 1'b0;
          beat_count <= '0;
        end
      end else begin
        if (end_stream)  stop_pend <= 1'b0;
        else if (stop)   stop_pend <= 1'b1;
        if (hs && (beat_count != 16'hFFFF))
          beat_count <= beat_count + 16'd1;
      end
    end
  end

  assign vec_valid = (state == STREAM);
  assign busy      = (state == STREAM);

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench for fft_frame_streamer: cycle-by-cycle vector table plus
// hand-written read-before-write and asynchronous-reset sequences.
module tb_fft_frame_streamer;

  localparam int FW  = 9;
  localparam int L   = 32;
  localparam int FR  = 6;
  localparam int AW  = 3;
  localparam int ADW = 9;
  localparam int VW  = FW * L;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [ADW-1:0] wr_addr = '0;
  logic [FW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] num_frames = '0;
  logic          loop_mode = 1'b0;
  logic          stop = 1'b0;
  logic          vec_valid;
  logic          vec_ready = 1'b0;
  logic [VW-1:0] vec_real, vec_imag;
  logic [AW-1:0] frame_idx;
  logic          busy, done;
  logic [15:0]   beat_count;

  fft_frame_streamer #(
    .FORMAT_WIDTH(FW), .LANES(L), .FRAMES(FR), .FRAME_AW(AW), .ADDR_WIDTH(ADW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_frames(num_frames), .loop_mode(loop_mode), .stop(stop),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_real(vec_real),
    .vec_imag(vec_imag), .frame_idx(frame_idx), .busy(busy), .done(done),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [AW-1:0] num;
    logic          loop;
    logic          stop;
    logic          ready;
    logic          e_valid;
    logic [AW-1:0] e_idx;
    logic          e_done;
    logic [15:0]   e_bc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected vector of frame f: lane k carries f*64+off+k, lane 0 in the MSB slot.
  function automatic logic [VW-1:0] exp_vec(input int f, input int off);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++)
      v[VW-1-k*FW -: FW] = FW'(f * 64 + off + k);
    return v;
  endfunction

  function automatic vec_t mk(input logic s, input logic [AW-1:0] n, input logic lp,
                              input logic sp, input logic rd, input logic ev,
                              input logic [AW-1:0] ei, input logic ed, input logic [15:0] eb);
    vec_t r;
    r.start = s;  r.num = n;  r.loop = lp; r.stop = sp; r.ready = rd;
    r.e_valid = ev; r.e_idx = ei; r.e_done = ed; r.e_bc = eb;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    wr_en = 1'b1; wr_addr = ADW'(a); wr_data = FW'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_row(input vec_t r, input int i);
    start = r.start; num_frames = r.num; loop_mode = r.loop; stop = r.stop; vec_ready = r.ready;
    tick();
    start = 1'b0; stop = 1'b0;
    check($sformatf("row%0d valid", i), VW'(vec_valid), VW'(r.e_valid));
    check($sformatf("row%0d busy", i), VW'(busy), VW'(r.e_valid));
    check($sformatf("row%0d done", i), VW'(done), VW'(r.e_done));
    check($sformatf("row%0d beat_count", i), VW'(beat_count), VW'(r.e_bc));
    if (r.e_valid) begin
      check($sformatf("row%0d frame_idx", i), VW'(frame_idx), VW'(r.e_idx));
      check($sformatf("row%0d real", i), vec_real, exp_vec(int'(r.e_idx), 0));
      check($sformatf("row%0d imag", i), vec_imag, exp_vec(int'(r.e_idx), 32));
    end
  endtask

  initial begin
    // 3 frames, no loop, ready high; a mid-stream start is ignored
    tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 5, 0, 0, 1, 1, 2, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 3));
    // start right after done, ready pattern 1,0,0,1,...
    tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 3));
    // 2 frames looping, stop together with a handshake at cycle 7
    tbl.push_back(mk(1, 2, 1, 0, 1, 1, 0, 0, 0));
    for (int c = 1; c <= 6; c++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, AW'(c % 2), 0, 16'(c)));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7));
    // stop while stalled is held pending until the next handshake
    tbl.push_back(mk(1, 2, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1));
    // num_frames=0 ignored, then num_frames=7 clamped to 6 beats
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 7, 0, 0, 1, 1, 0, 0, 0));
    for (int c = 1; c <= 5; c++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, AW'(c), 0, 16'(c)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 1, 6));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 6));

    #12;
    check("reset valid", VW'(vec_valid), '0);
    check("reset beat_count", VW'(beat_count), '0);
    check("reset real", vec_real, '0);
    rst = 1'b1;
    tick();

    for (int f = 0; f < FR; f++)
      for (int k = 0; k < 2 * L; k++)
        write_word(2 * L * f + k, f * 64 + k);
    write_word(2 * L * FR, 9'h155);  // out of range, must be dropped

    for (int i = 0; i < tbl.size(); i++)
      run_row(tbl[i], i);

    // write word 64 in the cycle frame 1 is loaded: old value first, new on next pass
    start = 1'b1; num_frames = 3'd2; loop_mode = 1'b1; vec_ready = 1'b0;
    tick();
    start = 1'b0; vec_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 9'd64; wr_data = 9'h1AB;
    tick();
    wr_en = 1'b0;
    check("rbw idx", VW'(frame_idx), VW'(1));
    check("rbw old lane0", VW'(vec_real[VW-1 -: FW]), VW'(64));
    tick();
    check("rbw wrap idx", VW'(frame_idx), VW'(0));
    tick();
    check("rbw new lane0", VW'(vec_real[VW-1 -: FW]), VW'(9'h1AB));
    check("rbw lane1", VW'(vec_real[VW-1-FW -: FW]), VW'(65));
    check("rbw imag", vec_imag, exp_vec(1, 32));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("rbw stop done", VW'(done), VW'(1));
    write_word(64, 64);

    // asynchronous reset mid-stream while stalled
    start = 1'b1; num_frames = 3'd3; loop_mode = 1'b0; vec_ready = 1'b0;
    tick();
    start = 1'b0; vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    check("pre-reset idx", VW'(frame_idx), VW'(1));
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst valid", VW'(vec_valid), '0);
    check("arst busy", VW'(busy), '0);
    check("arst done", VW'(done), '0);
    check("arst idx", VW'(frame_idx), '0);
    check("arst beat_count", VW'(beat_count), '0);
    check("arst real", vec_real, '0);
    check("arst imag", vec_imag, '0);
    #1;
    rst = 1'b1;
    tick();
    start = 1'b1; num_frames = 3'd3;
    tick();
    start = 1'b0;
    check("restart valid", VW'(vec_valid), VW'(1));
    check("restart idx", VW'(frame_idx), '0);
    check("restart real", vec_real, exp_vec(0, 0));
    check("restart imag", vec_imag, exp_vec(0, 32));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
